// File: rtl/instr_encoder.sv
// RV32 instruction encoder: turns decoded fields into machine words and writes them to instruction memory.
// Optional illegal-field checking is enabled by defining ENC_ILLEGAL_CHECK_EN.
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      cls,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [12:0]     imm,
    output logic            imem_we,
    output logic [31:0]     imem_addr,
    output logic [31:0]     imem_wdata,
    output logic            busy,
    output logic            done,
    output logic            full,
    output logic            err,
    output logic [ADDR_W:0] count
);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;

    localparam logic [31:0]     NOP   = 32'h0000_0013;
    localparam logic [2:0]      CLS_END = 3'd5;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e          state_q;
    logic [31:0]     addr_q;
    logic [31:0]     word_q;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] count_d;
    logic            full_q;
    logic [31:0]     word_d;
    logic            illegal_d;

    always_comb begin
        word_d    = NOP;
        illegal_d = 1'b0;
        case (cls)
            3'd0: word_d = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            3'd1: word_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            3'd2: word_d = {1'b0, funct7_5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
            3'd3: word_d = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            3'd4: word_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            default: word_d = NOP;
        endcase
`ifdef ENC_ILLEGAL_CHECK_EN
        case (cls)
            3'd2: illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011) ||
                              (funct7_5 && (funct3 != 3'b000));
            3'd4: illegal_d = !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100)) ||
                              imm[0];
            3'd6, 3'd7: illegal_d = 1'b1;
            default: illegal_d = 1'b0;
        endcase
        if (illegal_d) begin
            word_d = NOP;
        end
`endif
    end

    assign count_d = count_q + 1'b1;

`ifdef ENC_ILLEGAL_CHECK_EN
    logic err_q;

    // Sticky error latches together with the word it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            err_q <= 1'b0;
        end else if (state_q == ACCEPT && in_valid && cls != CLS_END) begin
            err_q <= err_q | illegal_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            word_q  <= 32'h0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACCEPT;
                        addr_q  <= BASE_ADDR;
                        count_q <= '0;
                        full_q  <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        if (cls == CLS_END) begin
                            state_q <= DONE;
                        end else begin
                            word_q  <= word_d;
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Address wraps naturally at 2**32.
                    addr_q  <= addr_q + 32'd4;
                    count_q <= count_d;
                    if (count_d == DEPTH) begin
                        full_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= ACCEPT;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == ACCEPT);
    assign imem_we    = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign full       = full_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder; a second small instance (ADDR_W=2) covers fill-up and address wrap.
module tb_instr_encoder;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BASE_S = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, start, startS, inValid, funct7_5, useSmall;
    logic [2:0]  cls, funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;

    logic        weM, readyM, busyM, doneM, fullM, errM;
    logic [31:0] addrM, dataM;
    logic [8:0]  countM;
    logic        weS, readyS, busyS, doneS, fullS, errS;
    logic [31:0] addrS, dataS;
    logic [2:0]  countS;

    logic        we, ready, busy, done, full, err;
    logic [31:0] addr, data;
    logic [8:0]  cnt;

    int checks = 0;
    int errors = 0;
    logic errModel;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(32'h0)) dutMain (
        .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_ready(readyM),
        .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7_5(funct7_5),
        .imm(imm), .imem_we(weM), .imem_addr(addrM), .imem_wdata(dataM), .busy(busyM),
        .done(doneM), .full(fullM), .err(errM), .count(countM)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(BASE_S)) dutSmall (
        .clk(clk), .rst(rst), .start(startS), .in_valid(inValid), .in_ready(readyS),
        .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7_5(funct7_5),
        .imm(imm), .imem_we(weS), .imem_addr(addrS), .imem_wdata(dataS), .busy(busyS),
        .done(doneS), .full(fullS), .err(errS), .count(countS)
    );

    assign we    = useSmall ? weS    : weM;
    assign ready = useSmall ? readyS : readyM;
    assign busy  = useSmall ? busyS  : busyM;
    assign done  = useSmall ? doneS  : doneM;
    assign full  = useSmall ? fullS  : fullM;
    assign err   = useSmall ? errS   : errM;
    assign addr  = useSmall ? addrS  : addrM;
    assign data  = useSmall ? dataS  : dataM;
    assign cnt   = useSmall ? {6'b0, countS} : countM;

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f75;
        logic [12:0] imm;
        logic [31:0] raw;
        logic        illegal;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("readyWait", {31'b0, ready}, 32'd1);
    endtask

    task automatic startLoad(input logic sel);
        useSmall = sel;
        if (sel) startS = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        startS = 1'b0;
        errModel = 1'b0;
    endtask

    task automatic driveFields(input vec_t v);
        cls = v.cls; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7_5 = v.f75; imm = v.imm;
    endtask

    task automatic applyStimulus(input vec_t v, input logic [31:0] expAddr, input int expCount, input logic last);
        logic [31:0] expWord;
        expWord = v.raw;
`ifdef ENC_ILLEGAL_CHECK_EN
        if (v.illegal) expWord = NOP;
        errModel = errModel | v.illegal;
`endif
        waitReady();
        driveFields(v);
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("writeWe", {31'b0, we}, 32'd1);
        checkOutput("writeAddr", addr, expAddr);
        checkOutput("writeData", data, expWord);
        checkOutput("writeErr", {31'b0, err}, {31'b0, errModel});
        @(posedge clk); #1;
        checkOutput("weOneCycle", {31'b0, we}, 32'd0);
        checkOutput("count", {23'b0, cnt}, expCount);
        checkOutput("full", {31'b0, full}, {31'b0, last});
        checkOutput("doneAfterWrite", {31'b0, done}, {31'b0, last});
        checkOutput("readyAfterWrite", {31'b0, ready}, {31'b0, !last});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] expAddr;

        vecs[0] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0,      32'h002081B3, 1'b0};
        vecs[1] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0,      32'h402081B3, 1'b0};
        vecs[2] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd8,      32'h00208463, 1'b0};
        vecs[3] = '{3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'h0010,   32'h01012283, 1'b0};
        vecs[4] = '{3'd1, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 13'h0024,   32'h02512223, 1'b0};
        vecs[5] = '{3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'h1FFF,   32'hFFF00093, 1'b0};
        vecs[6] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd1, 1'b0, 13'h1FFC,   32'hFE209EE3, 1'b0};
        vecs[7] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd2, 1'b0, 13'd0,      32'h0020A1B3, 1'b1};
        vecs[8] = '{3'd6, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0,      NOP,          1'b1};

        useSmall = 1'b0; errModel = 1'b0;
        rst = 1'b1; start = 1'b1; startS = 1'b1; inValid = 1'b1;
        cls = 3'd2; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7_5 = 1'b0; imm = 13'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstReady", {31'b0, ready}, 32'd0);
        checkOutput("rstWe", {31'b0, we}, 32'd0);
        checkOutput("rstAddr", addr, 32'd0);
        checkOutput("rstData", data, 32'd0);
        checkOutput("rstDone", {31'b0, done}, 32'd0);
        checkOutput("rstFull", {31'b0, full}, 32'd0);
        checkOutput("rstErr", {31'b0, err}, 32'd0);
        checkOutput("rstCount", {23'b0, cnt}, 32'd0);
        rst = 1'b0; start = 1'b0; startS = 1'b0; inValid = 1'b0;
        @(posedge clk); #1;

        startLoad(1'b0);
        checkOutput("startBusy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            applyStimulus(vecs[i], 32'(4 * i), i + 1, 1'b0);
        end

        waitReady();
        cls = 3'd5; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("endNoWrite", {31'b0, we}, 32'd0);
        checkOutput("endDone", {31'b0, done}, 32'd1);
        checkOutput("endCount", {23'b0, cnt}, 32'd9);
        @(posedge clk); #1;
        checkOutput("donePulse", {31'b0, done}, 32'd0);
        checkOutput("idleBusy", {31'b0, busy}, 32'd0);

        cls = 3'd2; inValid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("idleIgnoreWe", {31'b0, we}, 32'd0);
        checkOutput("idleIgnoreCount", {23'b0, cnt}, 32'd9);

        startLoad(1'b1);
        for (int i = 0; i < 4; i++) begin
            expAddr = BASE_S + 32'(4 * i);
            applyStimulus(vecs[i], expAddr, i + 1, i == 3);
        end
        driveFields(vecs[0]);
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("fullIgnoreWe", {31'b0, we}, 32'd0);
        checkOutput("fullIgnoreBusy", {31'b0, busy}, 32'd0);
        checkOutput("fullSticky", {31'b0, full}, 32'd1);
        checkOutput("fullCount", {23'b0, cnt}, 32'd4);

        startLoad(1'b0);
        waitReady();
        driveFields(vecs[0]);
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("midWriteWe", {31'b0, we}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midRstWe", {31'b0, we}, 32'd0);
        checkOutput("midRstAddr", addr, 32'd0);
        checkOutput("midRstData", data, 32'd0);
        checkOutput("midRstCount", {23'b0, cnt}, 32'd0);
        checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
        checkOutput("midRstReady", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("postRstWe", {31'b0, we}, 32'd0);
        checkOutput("postRstBusy", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8: log2 of instruction-memory depth in words.
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 SHALL provide ports, one per line:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin program load
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields
- cls  in  3  class: 0 LOAD, 1 STORE, 2 R, 3 I, 4 B, 5 END
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  funct3 field
- funct7_5  in  1  bit 30 for R-type
- imm  in  13  immediate (I/S use [11:0]; B uses [12:1], byte offset)
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  32  byte address, word-aligned
- imem_wdata  out  32  encoded instruction
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at load end
- full  out  1  sticky, memory filled
- err  out  1  sticky, illegal field combination seen
- count  out  ADDR_W+1  words written since start

Function
REQ-004 SHALL implement FSM states IDLE, ACCEPT, WRITE, DONE.
REQ-005 IDLE: in_ready=0; start=1 -> ACCEPT, addr<=BASE_ADDR, count<=0, err<=0, full<=0.
REQ-006 ACCEPT: in_ready=1; in_valid=1 with cls=END -> DONE, nothing written; other cls -> word registered, go WRITE.
REQ-007 WRITE: imem_we=1 for exactly one cycle with registered addr/word; next edge addr+=4, count+=1; if count reaches 2**ADDR_W -> full<=1, DONE; else ACCEPT.
REQ-008 DONE: done=1 for one cycle, then IDLE.
REQ-009 Latency: fields accepted at edge N -> imem_we high in cycle N+1 -> in_ready high again in cycle N+2.
REQ-010 start SHALL be ignored outside IDLE; in_valid ignored when in_ready=0.
REQ-011 Encodings, [31:0], opcode in [6:0]:
- LOAD  imm[11:0] | rs1 | funct3 | rd | 0000011
- STORE  imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | 0100011
- R  0 | funct7_5 | 00000 | rs2 | rs1 | funct3 | rd | 0110011
- I  imm[11:0] | rs1 | funct3 | rd | 0010011
- B  imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | 1100011
REQ-012 imem_addr SHALL wrap modulo 2**32; busy=1 in every state except IDLE.

Reset
REQ-013 rst=1 at a clock edge SHALL force IDLE from any state, including mid-WRITE, and clear in_ready, imem_we, imem_addr, imem_wdata, done, full, err, count to 0.
REQ-014 rst SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-015 Macro ENC_ILLEGAL_CHECK_EN defined: illegal inputs SHALL be written as NOP 32'h0000_0013 and set err, while still consuming one address. Illegal inputs are: cls 6-7; R funct3=010 or 011; R funct7_5=1 with funct3!=000; B funct3 not in {000,001,100}; B imm[0]=1.
REQ-016 Macro ENC_ILLEGAL_CHECK_EN undefined: fields SHALL be encoded raw, cls 6-7 SHALL write NOP, and err SHALL be tied 0.

Verification
REQ-017 start; R rd=3 rs1=1 rs2=2 funct3=0 funct7_5=0 -> imem_we one cycle, addr 0x0, wdata 0x002081B3, count=1.
REQ-018 Next: R same regs, funct7_5=1 -> addr 0x4, wdata 0x402081B3.
REQ-019 B rs1=1 rs2=2 funct3=0 imm=8 -> wdata 0x00208463.
REQ-020 With macro, R funct3=010 -> wdata 0x00000013, err=1, addr still advances by 4.
REQ-021 ADDR_W=2: four valid words -> full=1, done pulse after the 4th write, in_ready=0, fifth in_valid ignored.
REQ-022 rst asserted during WRITE -> no further imem_we, all outputs 0, IDLE next cycle.
